// File: rtl/bcd_to_binary_seq_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
package bcd_to_binary_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int DIGIT_W = 4;
   localparam logic [DIGIT_W-1:0] SUB3_THRESH = 4'd8;

endpackage

// File: rtl/bcd_to_binary_seq_if.sv
// Request/result bundle between a requester and the BCD-to-binary converter.
interface bcd_to_binary_seq_if
   import bcd_to_binary_seq_pkg::*;
#(
   parameter int DIGITS = 3,
   parameter int BIN_W  = 10
);
   logic                      start;
   logic [DIGIT_W*DIGITS-1:0] bcd_in;
   logic                      busy;
   logic                      done;
   logic [BIN_W-1:0]          bin_out;
   logic                      err;

   modport master (output start, bcd_in, input busy, done, bin_out, err);
   modport slave  (input start, bcd_in, output busy, done, bin_out, err);
endinterface

// File: rtl/bcd_to_binary_seq_sub3.sv
// Per-digit correction cell: inverse of the add-3 cell used by double dabble.
module sub3
   import bcd_to_binary_seq_pkg::*;
(
   input  logic [DIGIT_W-1:0] in,
   output logic [DIGIT_W-1:0] out
);
   assign out = (in >= SUB3_THRESH) ? in - 4'd3 : in;
endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter using reverse double dabble, one bit per clock.
//
// state | meaning
// IDLE  | waiting for start; bcd_in checked and captured here
// SHIFT | one shift/correct iteration per clock, BIN_W iterations
// DONE  | result latched; done pulses in the following cycle
module bcd_to_binary_seq
   import bcd_to_binary_seq_pkg::*;
#(
   parameter int DIGITS = 3,
   parameter int BIN_W  = 10
)(
   input  logic             clk,
   input  logic             reset_n,
   bcd_to_binary_seq_if.slave bus
);
   localparam int BCD_W  = DIGIT_W * DIGITS;
   localparam int ITER_W = $clog2(BIN_W + 1);
   localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(BIN_W - 1);

   state_t                  state;
   logic [BCD_W-1:0]        bcd_reg;
   logic [BIN_W-1:0]        bin_reg;
   logic [ITER_W-1:0]       iter;
   logic [BCD_W+BIN_W-1:0]  shifted;
   logic [BCD_W-1:0]        bcd_next;
   logic                    bad_digit;

   assign shifted = {bcd_reg, bin_reg} >> 1;

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      sub3 u_sub3 (
         .in  (shifted[BIN_W + g*DIGIT_W +: DIGIT_W]),
         .out (bcd_next[g*DIGIT_W +: DIGIT_W])
      );
   end

   always_comb begin
      bad_digit = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bus.bcd_in[i*DIGIT_W +: DIGIT_W] > 4'd9) bad_digit = 1'b1;
      end
   end

   // done follows the DONE state by one cycle so it is decoded purely from registered state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         bcd_reg     <= '0;
         bin_reg     <= '0;
         iter        <= '0;
         bus.busy    <= 1'b0;
         bus.done    <= 1'b0;
         bus.bin_out <= '0;
         bus.err     <= 1'b0;
      end else begin
         bus.done <= (state == DONE);
         case (state)
            IDLE: begin
               if (bus.start) begin
                  bus.busy <= 1'b1;
                  if (bad_digit) begin
                     state       <= DONE;
                     bus.err     <= 1'b1;
                     bus.bin_out <= '0;
                  end else begin
                     state   <= SHIFT;
                     bcd_reg <= bus.bcd_in;
                     bin_reg <= '0;
                     iter    <= '0;
                  end
               end
            end
            SHIFT: begin
               bcd_reg <= bcd_next;
               bin_reg <= shifted[BIN_W-1:0];
               iter    <= iter + ITER_W'(1);
               if (iter == LAST_ITER) begin
                  state       <= DONE;
                  bus.bin_out <= shifted[BIN_W-1:0];
                  bus.err     <= 1'b0;
               end
            end
            DONE: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Directed and sweep checks for the sequential BCD-to-binary converter.
module tb_bcd_to_binary_seq;
   import bcd_to_binary_seq_pkg::*;

   logic clk;
   logic reset_n;
   int   total = 0;
   int   bad   = 0;

   bcd_to_binary_seq_if #(.DIGITS(3), .BIN_W(10)) bus ();

   bcd_to_binary_seq #(.DIGITS(3), .BIN_W(10)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // one-cycle start, then wait for done; checks latency, busy span, result and pulse width
   task automatic convert(input logic [11:0] code, input int exp_lat, input logic [9:0] exp_bin,
                          input logic exp_err, input string tag);
      int n;
      int nb;
      bus.bcd_in = code;
      bus.start  = 1'b1;
      tick();
      bus.start = 1'b0;
      n  = 0;
      nb = 0;
      while (!bus.done && n < 40) begin
         if (bus.busy) nb++;
         tick();
         n++;
      end
      chk({tag, "_lat"}, n, exp_lat);
      chk({tag, "_busy"}, nb, exp_lat);
      chk({tag, "_bin"}, bus.bin_out, exp_bin);
      chk({tag, "_err"}, bus.err, exp_err);
      tick();
      chk({tag, "_pulse"}, bus.done, 1'b0);
   endtask

   initial begin
      int n;
      int m;
      int pulses;
      reset_n    = 1'b1;
      bus.start  = 1'b0;
      bus.bcd_in = '0;
      #2 reset_n = 1'b0;
      #1;
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_bin",  bus.bin_out, 10'd0);
      chk("rst_err",  bus.err, 1'b0);
      tick();
      tick();
      reset_n = 1'b1;

      convert(12'h999, 11, 10'd999, 1'b0, "c999");
      convert(12'h000, 11, 10'd0,   1'b0, "c000");
      convert(12'h255, 11, 10'd255, 1'b0, "c255");
      convert(12'h1A3, 1,  10'd0,   1'b1, "c1A3");
      convert(12'h123, 11, 10'd123, 1'b0, "c123");
      convert(12'h00F, 1,  10'd0,   1'b1, "c00F");
      convert(12'hA00, 1,  10'd0,   1'b1, "cA00");
      convert(12'h987, 11, 10'd987, 1'b0, "c987");

      bus.bcd_in = 12'h111;
      tick(); tick(); tick();
      chk("hold_bin", bus.bin_out, 10'd987);
      chk("hold_err", bus.err, 1'b0);

      // start re-pulsed mid-conversion with a new code must be ignored
      bus.bcd_in = 12'h500;
      bus.start  = 1'b1;
      tick();
      bus.start = 1'b0;
      tick(); tick();
      bus.start  = 1'b1;
      bus.bcd_in = 12'h777;
      tick();
      bus.start = 1'b0;
      n = 3;
      while (!bus.done && n < 40) begin
         tick();
         n++;
      end
      chk("ign_lat", n, 11);
      chk("ign_bin", bus.bin_out, 10'd500);
      pulses = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (bus.done) pulses++;
      end
      chk("ign_pulses", pulses, 0);

      // start held high: back-to-back conversions, one per DONE
      bus.bcd_in = 12'h042;
      bus.start  = 1'b1;
      tick();
      n = 0;
      while (!bus.done && n < 40) begin
         tick();
         n++;
      end
      chk("held_lat1", n, 11);
      chk("held_bin1", bus.bin_out, 10'd42);
      m = 0;
      tick();
      m++;
      while (!bus.done && m < 40) begin
         tick();
         m++;
      end
      bus.start = 1'b0;
      chk("held_gap", m, 12);
      chk("held_bin2", bus.bin_out, 10'd42);
      tick(); tick(); tick();

      // reset in the middle of a conversion
      bus.bcd_in = 12'h842;
      bus.start  = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      reset_n = 1'b0;
      #1;
      chk("mid_busy", bus.busy, 1'b0);
      chk("mid_done", bus.done, 1'b0);
      chk("mid_bin",  bus.bin_out, 10'd0);
      chk("mid_err",  bus.err, 1'b0);
      tick(); tick();
      reset_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (bus.done) pulses++;
      end
      chk("mid_pulses", pulses, 0);
      convert(12'h842, 11, 10'd842, 1'b0, "c842");

      for (int d2 = 0; d2 < 10; d2++) begin
         for (int d1 = 0; d1 < 10; d1++) begin
            for (int d0 = 0; d0 < 10; d0++) begin
               logic [11:0] code;
               code = {d2[3:0], d1[3:0], d0[3:0]};
               convert(code, 11, 10'(d2*100 + d1*10 + d0), 1'b0, "sweep");
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
